multicycle_alu: RTL and testbench
=================================

# multicycle_alu

Parametrised multi-cycle ALU with a start/done handshake, for the processor's execute stage. Single-cycle logic and arithmetic ops complete in one cycle. Unsigned multiply and divide run iteratively, one bit per cycle, and return a double-width product or a quotient/remainder pair. Operands are latched when an operation is accepted, so the control unit may change its source registers while the ALU is busy.

## Interface
- WIDTH, 16, operand and result width in bits; legal range 4..32.
- CNT_W, $clog2(WIDTH), width of the iteration counter; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on each rising edge of clk
- op  input  3  opcode, encoding given under Operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- busy  output  1  high while an iterative op is executing
- done  output  1  one-cycle pulse; result is valid from this cycle onward
- result  output  WIDTH  primary result; quotient for DIVU
- result_hi  output  WIDTH  product high half for MULU, remainder for DIVU, 0 otherwise
- zero  output  1  result == 0
- carry  output  1  carry/borrow flag, defined per op
- div_by_zero  output  1  last DIVU had b == 0

## Operation
- Opcodes:
  - 000 ADD, 001 SUB (a-b), 010 AND, 011 OR.
  - 100 XOR, 101 MULU, 110 DIVU, 111 SLT (signed a<b gives 1, else 0).
- FSM states: IDLE, EXEC, DONE.
- Accepting an op:
  - start is accepted only when the state is IDLE or DONE.
  - On acceptance, a, b and op are latched into internal registers.
  - start while in EXEC is ignored; no queueing.
- Single-cycle ops (ADD..XOR, SLT) and DIVU with b==0 go IDLE/DONE -> DONE. Result and flags are registered on the same edge.
- Iterative ops, MULU and DIVU with b!=0:
  - IDLE/DONE -> EXEC, counter loaded with WIDTH-1.
  - Each EXEC edge performs one iteration and decrements the counter.
  - On the edge where the counter is 0, go to DONE.
- From DONE: next state is IDLE unless a new start is accepted in that cycle.
- MULU: shift-add over a 2*WIDTH accumulator; {result_hi,result} = a*b.
- DIVU: restoring divide; result = a/b, result_hi = a%b.
- Divide by zero: result = all ones, result_hi = a, div_by_zero = 1.
- Flags are registered together with result:
  - zero: result == 0.
  - carry, ADD: carry-out.
  - carry, SUB: 1 when a>=b unsigned, i.e. no borrow.
  - carry, MULU: 1 when result_hi != 0.
  - carry, all other ops: 0.
  - div_by_zero: cleared on every accepted op other than DIVU-by-zero.
- Output hold: result, result_hi and flags hold their last values until the next op completes. During EXEC they keep the previous op's values; the working registers are internal.

## Timing
- Reset:
  - Asserting reset forces IDLE immediately, regardless of state; an in-flight op is discarded.
  - While reset is high, busy, done, result, result_hi, zero, carry and div_by_zero are all 0.
- Latency, with start accepted at edge k:
  - Single-cycle ops: done high in the cycle after edge k.
  - Iterative ops: busy high from edge k to edge k+WIDTH. done high in the cycle after edge k+WIDTH, so latency is WIDTH+... exactly WIDTH cycles of busy, then done.
- done and busy are never high together.
- Back-to-back: start held high during DONE starts the next op; peak throughput is one single-cycle op per clock.
- Simultaneous start and reset: reset wins.

## Structure
- Shared package alu_pkg:
  - op_t enum with the encodings above.
  - state_t enum {IDLE, EXEC, DONE}.
  - is_iterative(op) function.
- One sub-module, muldiv_iter, is natural. It holds the shift-add and restoring-divide datapath: accumulator, counter and one-step logic.
- The FSM, the single-cycle ops and the flag logic live in multicycle_alu.

## Test plan
All scenarios use WIDTH=16.
- ADD 0xFFFF + 0x0001 -> done 1 cycle after start, result=0x0000, zero=1, carry=1, busy never high.
- MULU 0x1234 * 0x0100 -> busy for 16 cycles, then done; result=0x3400, result_hi=0x0012, carry=1.
- DIVU 100 / 7 -> after 16 busy cycles, result=14, result_hi=2, div_by_zero=0.
- DIVU 0x0042 / 0 -> done 1 cycle after start, result=0xFFFF, result_hi=0x0042, div_by_zero=1.
- Start SUB while MULU is busy -> SUB is ignored and MULU completes correctly. SUB 5-7 issued in the DONE cycle -> result=0xFFFE, carry=0, done on the next cycle. SLT 0x8000, 0x0001 -> result=1.
- Assert reset at cycle 5 of a MULU -> all outputs 0 immediately. After release, ADD 3+4 gives result=7.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/state types for the multi-cycle ALU and its iterative datapath.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_MULU = 3'b101,
    OP_DIVU = 3'b110,
    OP_SLT  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_iterative(input op_t op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-cycle unsigned shift-add multiplier and restoring divider
// sharing a single 2*WIDTH accumulator.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_is_div,
  input  logic             i_step,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_m;
  logic               r_div;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_shift;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_acc_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= CNT_W'(WIDTH - 1);
    else if (i_step)
      r_cnt <= r_cnt - 1'b1;
  end

  // Multiply keeps the multiplier in the low half; divide keeps the dividend there
  // and grows the quotient into it as the remainder fills the high half.
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_acc <= {{WIDTH{1'b0}}, (i_is_div ? i_a : i_b)};
      r_m   <= i_is_div ? i_b : i_a;
      r_div <= i_is_div;
    end else if (i_step) begin
      r_acc <= w_acc_nxt;
    end
  end

  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
  assign w_mul_nxt = {w_sum, r_acc[WIDTH-1:1]};

  // Remainder stays below the divisor, so the difference always fits in WIDTH bits.
  assign w_shift   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge      = (w_shift >= {1'b0, r_m});
  assign w_rem_sub = w_shift[WIDTH-1:0] - r_m;
  assign w_div_nxt = w_ge ? {w_rem_sub, r_acc[WIDTH-2:0], 1'b1}
                          : {r_acc[2*WIDTH-2:0], 1'b0};

  assign w_acc_nxt = r_div ? w_div_nxt : w_mul_nxt;
  assign o_lo      = w_acc_nxt[WIDTH-1:0];
  assign o_hi      = w_acc_nxt[2*WIDTH-1:WIDTH];
  assign o_last    = (r_cnt == '0);

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/arithmetic plus iterative MULU/DIVU,
// with a start/done handshake and registered result/flags.
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             div_by_zero
);

  state_t           r_state;
  state_t           w_state_nxt;
  op_t              r_op;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_zero;
  logic             r_carry;
  logic             r_dbz;

  op_t                     w_op;
  logic                    w_accept;
  logic                    w_iter;
  logic                    w_last;
  logic [WIDTH-1:0]        w_it_lo;
  logic [WIDTH-1:0]        w_it_hi;
  logic signed [WIDTH-1:0] w_a_s;
  logic signed [WIDTH-1:0] w_b_s;
  logic [WIDTH-1:0]        w_sc_res;
  logic [WIDTH-1:0]        w_sc_hi;
  logic                    w_sc_carry;
  logic                    w_sc_dbz;

  assign w_op     = op_t'(op);
  assign w_accept = start && (r_state != EXEC);
  // Divide by zero short-circuits to a one-cycle result instead of iterating.
  assign w_iter   = is_iterative(w_op) && !((w_op == OP_DIVU) && (b == '0));
  assign w_a_s    = a;
  assign w_b_s    = b;

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_accept && w_iter),
    .i_is_div (w_op == OP_DIVU),
    .i_step   (r_state == EXEC),
    .i_a      (a),
    .i_b      (b),
    .o_last   (w_last),
    .o_lo     (w_it_lo),
    .o_hi     (w_it_hi)
  );

  always_comb begin
    w_sc_res   = '0;
    w_sc_hi    = '0;
    w_sc_carry = 1'b0;
    w_sc_dbz   = 1'b0;
    case (w_op)
      OP_ADD:  {w_sc_carry, w_sc_res} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        w_sc_res   = a - b;
        w_sc_carry = (a >= b);
      end
      OP_AND:  w_sc_res = a & b;
      OP_OR:   w_sc_res = a | b;
      OP_XOR:  w_sc_res = a ^ b;
      OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
      OP_DIVU: begin
        w_sc_res = '1;
        w_sc_hi  = a;
        w_sc_dbz = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (w_accept)
          w_state_nxt = w_iter ? EXEC : DONE;
        else
          w_state_nxt = IDLE;
      end
      EXEC:    if (w_last) w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= OP_ADD;
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && !w_iter) begin
        r_result    <= w_sc_res;
        r_result_hi <= w_sc_hi;
        r_zero      <= (w_sc_res == '0);
        r_carry     <= w_sc_carry;
        r_dbz       <= w_sc_dbz;
      end else if (w_accept) begin
        r_op  <= w_op;
        r_dbz <= 1'b0;
      end else if ((r_state == EXEC) && w_last) begin
        r_result    <= w_it_lo;
        r_result_hi <= w_it_hi;
        r_zero      <= (w_it_lo == '0);
        r_carry     <= (r_op == OP_MULU) && (w_it_hi != '0);
      end
    end
  end

  assign busy        = (r_state == EXEC);
  assign done        = (r_state == DONE);
  assign result      = r_result;
  assign result_hi   = r_result_hi;
  assign zero        = r_zero;
  assign carry       = r_carry;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu at WIDTH=16.
module tb_multicycle_alu;

  localparam int W = 16;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, MULU = 3'd5, DIVU = 3'd6, SLT = 3'd7;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, zero, carry, div_by_zero;
  logic [W-1:0] result, result_hi;

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         z;
    logic         c;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .result_hi   (result_hi),
    .zero        (zero),
    .carry       (carry),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input string tag, input logic [2:0] o,
                                 input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t           e;
    logic [2*W-1:0] p;
    logic [W:0]     s;
    e.tag = tag; e.res = '0; e.hi = '0; e.c = 1'b0; e.dbz = 1'b0;
    case (o)
      ADD:  begin s = {1'b0, x} + {1'b0, y}; e.res = s[W-1:0]; e.c = s[W]; end
      SUB:  begin e.res = x - y; e.c = (x >= y); end
      AND_: e.res = x & y;
      OR_:  e.res = x | y;
      XOR_: e.res = x ^ y;
      MULU: begin p = 32'(x) * 32'(y); e.res = p[W-1:0]; e.hi = p[2*W-1:W]; e.c = (e.hi != 0); end
      DIVU: begin
        if (y == 0) begin e.res = '1; e.hi = x; e.dbz = 1'b1; end
        else begin e.res = x / y; e.hi = x % y; end
      end
      default: e.res = ($signed(x) < $signed(y)) ? 16'd1 : 16'd0;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && done) begin
      n_done++;
      check_val("busy_with_done", busy, 0);
      check_val("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val({e.tag, ".result"}, result, e.res);
        check_val({e.tag, ".result_hi"}, result_hi, e.hi);
        check_val({e.tag, ".zero"}, zero, e.z);
        check_val({e.tag, ".carry"}, carry, e.c);
        check_val({e.tag, ".div_by_zero"}, div_by_zero, e.dbz);
      end
    end
  end

  task automatic issue(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    op = o; a = x; b = y; start = 1'b1;
    sb.push_back(model(tag, o, x, y));
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input int exp_lat);
    int lat, bc;
    @(posedge clk); #1;
    issue(tag, o, x, y);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; bc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
      if (busy) bc++;
    end
    check_val({tag, ".done_seen"}, done, 1);
    check_val({tag, ".latency"}, lat, exp_lat);
    check_val({tag, ".busy_cycles"}, bc, exp_lat - 1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, ".busy"}, busy, 0);
    check_val({tag, ".done"}, done, 0);
    check_val({tag, ".result"}, result, 0);
    check_val({tag, ".result_hi"}, result_hi, 0);
    check_val({tag, ".zero"}, zero, 0);
    check_val({tag, ".carry"}, carry, 0);
    check_val({tag, ".div_by_zero"}, div_by_zero, 0);
  endtask

  initial begin
    int d0;
    logic [2:0]   ro;
    logic [W-1:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) reset = 1'b0;

    run("add_wrap", ADD, 16'hFFFF, 16'h0001, 1);
    @(negedge clk);
    check_val("done_one_pulse", done, 0);

    run("mulu", MULU, 16'h1234, 16'h0100, W + 1);
    run("divu", DIVU, 16'd100, 16'd7, W + 1);
    run("divu_zero", DIVU, 16'h0042, 16'h0000, 1);

    // MULU with a SUB attempted mid-flight, then a SUB issued in the DONE cycle
    @(posedge clk); #1;
    issue("mulu_busy", MULU, 16'h00FF, 16'h00FF);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_val("hold_in_exec.result", result, 16'hFFFF);
    check_val("hold_in_exec.result_hi", result_hi, 16'h0042);
    @(posedge clk); #1;
    op = SUB; a = 16'd5; b = 16'd7; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check_val("mulu_busy.done_seen", done, 1);
    issue("sub_in_done", SUB, 16'd5, 16'd7);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_val("sub_in_done.done", done, 1);

    run("slt_neg", SLT, 16'h8000, 16'h0001, 1);
    run("slt_pos", SLT, 16'h0001, 16'h8000, 1);

    // Back-to-back single-cycle ops with start held high
    @(posedge clk); #1;
    d0 = n_done;
    issue("b2b_and", AND_, 16'hF0F0, 16'hFF00);
    @(posedge clk); #1;
    issue("b2b_or", OR_, 16'hF0F0, 16'h0F0F);
    @(posedge clk); #1;
    issue("b2b_xor", XOR_, 16'hAAAA, 16'hAAAA);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    check_val("b2b.done_count", n_done - d0, 3);

    for (int i = 0; i < 8; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = (i == 3) ? 16'h0000 : 16'($urandom);
      run("rand", ro, ra, rb, ((ro == MULU) || (ro == DIVU && rb != 0)) ? W + 1 : 1);
    end

    // Reset in the middle of a MULU discards it
    run("divu_zero2", DIVU, 16'h0042, 16'h0000, 1);
    @(posedge clk); #1;
    issue("mulu_rst", MULU, 16'h1234, 16'h0100);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("pre_rst.busy", busy, 1);
    reset = 1'b1;
    #1;
    check_all_zero("mid_rst");
    sb.delete();
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    run("add_after_rst", ADD, 16'd3, 16'd4, 1);

    @(negedge clk);
    check_val("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
